// File: rtl/ising_pkg.sv
// ising_pkg: lattice size, FSM state type and datapath widths shared by the Ising observables block.
package ising_pkg;
  localparam int N = 32;
  localparam int E_W = 14;
  localparam int M_W = 12;
  localparam int F_W = 16;
  localparam int ONES_W = 11;
  localparam int MIS_W = 12;
  localparam int PC_W = 6;
  typedef enum logic [1:0] {IDLE, ACCUM, CLOSE, DONE} state_t;
endpackage

// File: rtl/popcount32.sv
// popcount32: combinational count of set bits in a 32-bit word.
module popcount32 (
  input  logic [31:0] x,
  output logic [5:0]  cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) cnt = cnt + 6'(x[i]);
  end
endmodule

// File: rtl/ising_observables.sv
// ising_observables: streams an NxN periodic spin lattice row by row and reports energy, magnetisation and frame count.
module ising_observables #(
  parameter int N = ising_pkg::N
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       row_valid,
  input  logic [N-1:0]               row_data,
  output logic                       row_ready,
  output logic [ising_pkg::E_W-1:0]  energy,
  output logic [ising_pkg::M_W-1:0]  magnet,
  output logic [ising_pkg::F_W-1:0]  frame_idx,
  output logic                       out_valid,
  input  logic                       out_ready
);
  import ising_pkg::*;
  localparam int R_W = $clog2(N);
  state_t state;
  logic [N-1:0] first_row, prev_row, v_in;
  logic [R_W-1:0] row_cnt;
  logic [ONES_W-1:0] ones;
  logic [MIS_W-1:0] mis;
  logic [PC_W-1:0] pc_ones, pc_h, pc_v;
  assign row_ready = state == ACCUM;
  // the vertical counter is reused in CLOSE for the row N-1 / row 0 wrap bonds
  assign v_in = state == CLOSE ? prev_row ^ first_row : row_data ^ prev_row;
  popcount32 u_ones (.x(row_data), .cnt(pc_ones));
  popcount32 u_h (.x(row_data ^ {row_data[N-2:0], row_data[N-1]}), .cnt(pc_h));
  popcount32 u_v (.x(v_in), .cnt(pc_v));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      first_row <= '0;
      prev_row <= '0;
      row_cnt <= '0;
      ones <= '0;
      mis <= '0;
      energy <= '0;
      magnet <= '0;
      frame_idx <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          ones <= '0;
          mis <= '0;
          row_cnt <= '0;
        end
        ACCUM: if (row_valid) begin
          ones <= ones + ONES_W'(pc_ones);
          mis <= mis + MIS_W'(pc_h) + (row_cnt != '0 ? MIS_W'(pc_v) : '0);
          if (row_cnt == '0) first_row <= row_data;
          prev_row <= row_data;
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == R_W'(N - 1)) state <= CLOSE;
        end
        CLOSE: begin
          mis <= mis + MIS_W'(pc_v);
          state <= DONE;
        end
        DONE: if (!out_valid) begin
          energy <= {mis, 2'b00} - E_W'(4 * N * N);
          magnet <= {ones, 1'b0} - M_W'(N * N);
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          frame_idx <= frame_idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ising_observables.sv
// tb_ising_observables: directed frames with hand-computed energy/magnet, latency, hold and reset checks.
module tb_ising_observables;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, row_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] row_data = '0;
  logic row_ready, out_valid;
  logic [13:0] energy;
  logic [11:0] magnet;
  logic [15:0] frame_idx;
  int errs = 0, checks = 0, exp_idx = 0;
  logic [31:0] rows [32];
  always #5 clk = ~clk;
  ising_observables dut (
    .clk(clk), .reset_n(reset_n), .start(start), .row_valid(row_valid), .row_data(row_data),
    .row_ready(row_ready), .energy(energy), .magnet(magnet), .frame_idx(frame_idx),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input bit gaps);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("row_ready_accum", row_ready, 1);
    for (int k = 0; k < 32; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        row_valid = 1'b0;
        row_data = $urandom;
        tick();
      end
      row_valid = 1'b1;
      row_data = rows[k];
      tick();
    end
    row_valid = 1'b0;
    check("lat0", out_valid, 0);
    tick();
    check("lat1", out_valid, 0);
    tick();
    check("lat2", out_valid, 1);
  endtask
  task automatic finish_frame(input int e, input int m, input bit hold);
    check("energy", $signed(energy), e);
    check("magnet", $signed(magnet), m);
    check("idx_pending", frame_idx, exp_idx);
    if (hold) repeat (10) begin
      start = 1'b1;
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_energy", $signed(energy), e);
      check("hold_magnet", $signed(magnet), m);
      check("hold_no_accept", row_ready, 0);
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    exp_idx++;
    check("handshake_valid", out_valid, 0);
    check("frame_idx", frame_idx, exp_idx);
    tick();
    check("idle_after", row_ready, 0);
  endtask
  initial begin
    repeat (2) tick();
    check("rst_row_ready", row_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_energy", energy, 0);
    check("rst_magnet", magnet, 0);
    check("rst_frame_idx", frame_idx, 0);
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) rows[k] = 32'hFFFFFFFF;
    run_frame(0);
    finish_frame(-4096, 1024, 0);
    for (int k = 0; k < 32; k++) rows[k] = 32'h0;
    run_frame(0);
    finish_frame(-4096, -1024, 0);
    run_frame(0);
    finish_frame(-4096, -1024, 0);
    for (int k = 0; k < 32; k++) rows[k] = k[0] ? 32'h55555555 : 32'hAAAAAAAA;
    run_frame(0);
    finish_frame(4096, 0, 0);
    for (int k = 0; k < 32; k++) rows[k] = 32'hFFFF0000;
    run_frame(0);
    finish_frame(-3840, 0, 0);
    for (int k = 0; k < 32; k++) rows[k] = (k == 5) ? 32'h00000100 : 32'h0;
    run_frame(0);
    finish_frame(-4080, -1022, 0);
    run_frame(1);
    finish_frame(-4080, -1022, 1);
    for (int k = 0; k < 32; k++) rows[k] = 32'hFFFFFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      row_valid = 1'b1;
      row_data = rows[k];
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_row_ready", row_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_energy", energy, 0);
    check("mid_rst_magnet", magnet, 0);
    check("mid_rst_frame_idx", frame_idx, 0);
    row_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_idx = 0;
    run_frame(0);
    finish_frame(-4096, 1024, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
